// File: rtl/lcg_pkg.sv
// Shared types and constants for the LCG seed search: default widths, latency derivation,
// search FSM states and the latched search configuration.
package lcg_pkg;

  localparam int unsigned LCG_WIDTH    = 32;
  localparam int unsigned LCG_STEP_LAT = 1;

  // Total compare latency for three chained steps.
  function automatic int unsigned lcg_lat(input int unsigned step_lat);
    return 3 * step_lat;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  typedef struct packed {
    logic [LCG_WIDTH-1:0] m;
    logic [LCG_WIDTH-1:0] a;
    logic [LCG_WIDTH-1:0] c;
    logic [LCG_WIDTH-1:0] seed_lo;
    logic [LCG_WIDTH-1:0] seed_hi;
    logic [LCG_WIDTH-1:0] t0;
    logic [LCG_WIDTH-1:0] t1;
    logic [LCG_WIDTH-1:0] t2;
  } cfg_t;

endpackage

// File: rtl/lcg_step.sv
// One LCG step x' = (x*a + c) mod m at full precision, followed by STEP_LAT register stages
// carrying the result, its seed tag and a valid bit.
module lcg_step
  import lcg_pkg::*;
#(
  parameter int unsigned WIDTH    = LCG_WIDTH,
  parameter int unsigned STEP_LAT = LCG_STEP_LAT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             flush,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] tag_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] tag_out,
  output logic             valid_out
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH:0]   sum;
  logic [WIDTH-1:0]   nxt;

  assign prod = {{WIDTH{1'b0}}, x_in} * {{WIDTH{1'b0}}, a};
  assign sum  = {1'b0, prod} + {{(WIDTH + 1){1'b0}}, c};
  // m == 0 is rejected before any seed is issued; the guard only keeps the datapath defined.
  assign nxt  = (m == '0) ? '0 : WIDTH'(sum % {{(WIDTH + 1){1'b0}}, m});

  logic [WIDTH-1:0] x_q   [STEP_LAT];
  logic [WIDTH-1:0] tag_q [STEP_LAT];
  logic             vld_q [STEP_LAT];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(STEP_LAT); i++) begin
        x_q[i]   <= '0;
        tag_q[i] <= '0;
        vld_q[i] <= 1'b0;
      end
    end else begin
      x_q[0]   <= nxt;
      tag_q[0] <= tag_in;
      vld_q[0] <= valid_in & ~flush;
      for (int i = 1; i < int'(STEP_LAT); i++) begin
        x_q[i]   <= x_q[i-1];
        tag_q[i] <= tag_q[i-1];
        vld_q[i] <= vld_q[i-1] & ~flush;
      end
    end
  end

  assign x_out     = x_q[STEP_LAT-1];
  assign tag_out   = tag_q[STEP_LAT-1];
  assign valid_out = vld_q[STEP_LAT-1];

endmodule

// File: rtl/lcg_seed_search.sv
// Brute-force LCG seed recovery: sweeps [seed_lo, seed_hi] one seed per clock through three
// chained steps and reports the lowest seed whose three outputs match the targets.
module lcg_seed_search
  import lcg_pkg::*;
#(
  parameter int unsigned WIDTH    = LCG_WIDTH,
  parameter int unsigned STEP_LAT = LCG_STEP_LAT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] MODULUS,
  input  logic [WIDTH-1:0] MULTIPLIER,
  input  logic [WIDTH-1:0] INCREMENT,
  input  logic [WIDTH-1:0] seed_lo,
  input  logic [WIDTH-1:0] seed_hi,
  input  logic [WIDTH-1:0] target0,
  input  logic [WIDTH-1:0] target1,
  input  logic [WIDTH-1:0] target2,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] found_seed,
  output logic [WIDTH:0]   seeds_tried,
  output logic             cfg_err
);

  localparam int LAT = int'(lcg_lat(STEP_LAT));
  localparam int D0  = LAT - int'(STEP_LAT);
  localparam int D1  = int'(STEP_LAT);

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic             found_q, found_d;
  logic [WIDTH-1:0] fseed_q, fseed_d;
  logic [WIDTH:0]   tried_q, tried_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] x_c   [4];
  logic [WIDTH-1:0] tag_c [4];
  logic             vld_c [4];
  logic             cmp_valid, hit, flush;
  logic [WIDTH-1:0] v0, v1;

  // cfg_q.seed_lo doubles as the sweep cursor: it advances as each seed is issued.
  assign x_c[0]   = cfg_q.seed_lo;
  assign tag_c[0] = cfg_q.seed_lo;
  assign vld_c[0] = (state_q == RUN);

  for (genvar k = 0; k < 3; k++) begin : g_step
    lcg_step #(
      .WIDTH   (WIDTH),
      .STEP_LAT(STEP_LAT)
    ) u_step (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .flush    (flush),
      .m        (cfg_q.m),
      .a        (cfg_q.a),
      .c        (cfg_q.c),
      .x_in     (x_c[k]),
      .tag_in   (tag_c[k]),
      .valid_in (vld_c[k]),
      .x_out    (x_c[k+1]),
      .tag_out  (tag_c[k+1]),
      .valid_out(vld_c[k+1])
    );
  end

  // Align v0 and v1 with the stage-2 output.
  logic [WIDTH-1:0] d0_q [D0];
  logic [WIDTH-1:0] d1_q [D1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < D0; i++) d0_q[i] <= '0;
      for (int i = 0; i < D1; i++) d1_q[i] <= '0;
    end else begin
      d0_q[0] <= x_c[1];
      for (int i = 1; i < D0; i++) d0_q[i] <= d0_q[i-1];
      d1_q[0] <= x_c[2];
      for (int i = 1; i < D1; i++) d1_q[i] <= d1_q[i-1];
    end
  end

  assign v0 = d0_q[D0-1];
  assign v1 = d1_q[D1-1];

  assign cmp_valid = vld_c[3] && ((state_q == RUN) || (state_q == DRAIN));
  assign hit       = cmp_valid && (v0 == cfg_q.t0) && (v1 == cfg_q.t1) && (x_c[3] == cfg_q.t2);
  assign flush     = abort | hit;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    found_d = found_q;
    fseed_d = fseed_q;
    tried_d = tried_q;
    err_d   = err_q;
    if (abort) begin
      state_d = IDLE;
      found_d = 1'b0;
      fseed_d = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            cfg_d = '{m: MODULUS, a: MULTIPLIER, c: INCREMENT, seed_lo: seed_lo,
                      seed_hi: seed_hi, t0: target0, t1: target1, t2: target2};
            found_d = 1'b0;
            fseed_d = '0;
            tried_d = '0;
            err_d   = 1'b0;
            if (MODULUS == '0) begin
              state_d = DONE;
              err_d   = 1'b1;
            end else if (seed_lo > seed_hi) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
          end
        end
        RUN, DRAIN: begin
          if (cmp_valid) tried_d = tried_q + 1'b1;
          if (hit) begin
            found_d = 1'b1;
            fseed_d = tag_c[3];
            state_d = DONE;
          end else if (state_q == RUN) begin
            // Compare before incrementing so seed_hi = all-ones never wraps.
            if (cfg_q.seed_lo == cfg_q.seed_hi) state_d = DRAIN;
            else cfg_d.seed_lo = cfg_q.seed_lo + 1'b1;
          end else if (cmp_valid && (tag_c[3] == cfg_q.seed_hi)) begin
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      found_q <= 1'b0;
      fseed_q <= '0;
      tried_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      found_q <= found_d;
      fseed_q <= fseed_d;
      tried_q <= tried_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign found       = found_q;
  assign found_seed  = fseed_q;
  assign seeds_tried = tried_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_lcg_seed_search.sv
// Randomized and directed bench for lcg_seed_search, checked every cycle against a
// search model that enumerates the seed range with plain arithmetic.
module tb_lcg_seed_search;

  localparam int LAT = 3;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] modulus = '0, mult = '0, incr = '0, lo = '0, hi = '0;
  logic [31:0] t0 = '0, t1 = '0, t2 = '0;
  logic        busy, done, found, cfg_err;
  logic [31:0] found_seed;
  logic [32:0] seeds_tried;

  lcg_seed_search dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .abort      (abort),
    .MODULUS    (modulus),
    .MULTIPLIER (mult),
    .INCREMENT  (incr),
    .seed_lo    (lo),
    .seed_hi    (hi),
    .target0    (t0),
    .target1    (t1),
    .target2    (t2),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .found_seed (found_seed),
    .seeds_tried(seeds_tried),
    .cfg_err    (cfg_err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic        chk_en = 1'b0, chk_tried = 1'b0;
  logic        exp_busy = 1'b0, exp_done = 1'b0, exp_found = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_fseed = '0;
  logic [32:0] exp_tried = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] lcg(input logic [31:0] x, input logic [31:0] a,
                                      input logic [31:0] c, input logic [31:0] m);
    logic [64:0] s;
    s = 65'(x) * 65'(a) + 65'(c);
    return 32'(s % 65'(m));
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(exp_done));
      chk("found", 64'(found), 64'(exp_found));
      chk("found_seed", 64'(found_seed), 64'(exp_fseed));
      chk("cfg_err", 64'(cfg_err), 64'(exp_err));
      if (chk_tried) chk("seeds_tried", 64'(seeds_tried), 64'(exp_tried));
    end
  end

  // Runs one search with the current config. Iteration i describes the state after the i-th
  // clock edge following the edge that samples start. Negative *_at values disable an event.
  task automatic run_search(input int abort_at, input int rst_at, input int xstart_at,
                            output int done_at);
    bit          imm, f, err, killed, kill_tried;
    logic [31:0] fs, x1, x2, x3, s;
    longint      n, k, fin, d, i, last;
    imm = 0; f = 0; err = 0; killed = 0; kill_tried = 0;
    fs = '0; fin = 0; d = 0; done_at = -1;
    if (modulus == 0) begin
      imm = 1; err = 1;
    end else if (lo > hi) begin
      imm = 1;
    end else begin
      n = longint'(hi) - longint'(lo) + 1;
      k = 0;
      while (k < n && !f) begin
        s  = 32'(longint'(lo) + k);
        x1 = lcg(s, mult, incr, modulus);
        x2 = lcg(x1, mult, incr, modulus);
        x3 = lcg(x2, mult, incr, modulus);
        if (x1 == t0 && x2 == t1 && x3 == t2) begin
          f = 1; fs = s;
        end
        k++;
      end
      fin = k;
      d   = fin + LAT;
    end
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    i = 0; last = d + 2;
    while (i <= last) begin
      start = (i == longint'(xstart_at));
      abort = (i == longint'(abort_at));
      if (abort_at >= 0 && i == longint'(abort_at) + 1) begin
        killed = 1; last = i + 2;
      end
      if (i == longint'(rst_at)) begin
        RST_N = 1'b0; killed = 1; kill_tried = 1; last = i + 2;
      end else begin
        RST_N = 1'b1;
      end
      if (killed) begin
        exp_busy = 0; exp_done = 0; exp_found = 0; exp_fseed = '0; exp_err = 0;
        exp_tried = '0; chk_tried = kill_tried;
      end else if (imm) begin
        exp_busy = 0; exp_done = 1; exp_found = 0; exp_fseed = '0; exp_err = err;
        exp_tried = '0; chk_tried = 1;
      end else begin
        exp_busy  = (i < d);
        exp_done  = (i >= d);
        exp_found = f && (i >= d);
        exp_fseed = (f && i >= d) ? fs : 32'd0;
        exp_err   = 0;
        exp_tried = (i < LAT) ? 33'd0 : ((i - LAT > fin) ? 33'(fin) : 33'(i - LAT));
        chk_tried = 1;
      end
      chk_en = 1'b1;
      @(negedge CLK);
      if (done === 1'b1 && done_at < 0 && !killed) done_at = int'(i);
      @(posedge CLK); #1;
      i++;
    end
    chk_en = 1'b0; start = 1'b0; abort = 1'b0; RST_N = 1'b1;
  endtask

  task automatic cfg_first();
    modulus = 32'd993441; mult = 32'd4001; incr = 32'd60211;
    lo = 32'd0; hi = 32'd200; t0 = 32'd444307; t1 = 32'd466569; t2 = 32'd127141;
  endtask

  task automatic check_first(input string tag, input int dat);
    chk({tag, "_done_cycle"}, 64'(dat), 64'd100);
    chk({tag, "_found"}, 64'(found), 64'd1);
    chk({tag, "_found_seed"}, 64'(found_seed), 64'd96);
    chk({tag, "_tried"}, 64'(seeds_tried), 64'd97);
  endtask

  initial begin
    int          dat;
    int unsigned len;
    logic [31:0] s;

    repeat (2) @(negedge CLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_found_seed", 64'(found_seed), 64'd0);
    chk("rst_tried", 64'(seeds_tried), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    #2 RST_N = 1'b1;

    cfg_first();
    run_search(-5, -5, -5, dat);
    check_first("t1", dat);

    t0 = '0; t1 = '0; t2 = '0; hi = 32'd9;
    run_search(-5, -5, -5, dat);
    chk("t2_done_cycle", 64'(dat), 64'(10 + LAT));
    chk("t2_found", 64'(found), 64'd0);
    chk("t2_tried", 64'(seeds_tried), 64'd10);

    lo = 32'hFFFF_FFFF; hi = 32'hFFFF_FFFF; modulus = 32'hFFFF_FFFB; mult = 32'd1;
    incr = 32'd1; t0 = 32'd1; t1 = 32'd2; t2 = 32'd3;
    run_search(-5, -5, -5, dat);
    chk("t3_done_cycle", 64'(dat), 64'(1 + LAT));
    chk("t3_found", 64'(found), 64'd0);
    chk("t3_tried", 64'(seeds_tried), 64'd1);

    cfg_first(); modulus = '0;
    run_search(-5, -5, -5, dat);
    chk("m0_done_cycle", 64'(dat), 64'd0);
    chk("m0_cfg_err", 64'(cfg_err), 64'd1);

    cfg_first(); lo = 32'd5; hi = 32'd2;
    run_search(-5, -5, -5, dat);
    chk("lohi_done_cycle", 64'(dat), 64'd0);
    chk("lohi_tried", 64'(seeds_tried), 64'd0);

    cfg_first();
    run_search(20, -5, -5, dat);
    run_search(-5, -5, 10, dat);
    check_first("after_abort", dat);
    run_search(-5, 30, -5, dat);
    run_search(-5, -5, -5, dat);
    check_first("after_reset", dat);

    for (int r = 0; r < 12; r++) begin
      modulus = (r % 2 == 0) ? 32'($urandom_range(2, 5000)) : ($urandom | 32'd1);
      mult = $urandom; incr = $urandom;
      len  = $urandom_range(1, 40);
      lo   = $urandom & 32'h7FFF_FFFF;
      hi   = lo + len - 1;
      if (r % 3 != 2) begin
        s  = lo + $urandom_range(0, len - 1);
        t0 = lcg(s, mult, incr, modulus);
        t1 = lcg(t0, mult, incr, modulus);
        t2 = lcg(t1, mult, incr, modulus);
      end else begin
        t0 = $urandom; t1 = $urandom; t2 = $urandom;
      end
      run_search(-5, -5, -5, dat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
